// File: rtl/pp_hop_loader.sv
// Ping-pong hop loader: steers each upstream packet into one of two parser hop
// FIFOs in strict alternation, queuing its RCI and holding the buffer until parse_done.
module pp_hop_loader #(
   parameter int MAX_HOPS   = 32,
   parameter int HCNT_NBITS = 6,
   parameter int STAT_NBITS = 16,
   parameter int HOP_NBITS  = 32,
   parameter int RCI_NBITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_hop_valid,
   input  logic [HOP_NBITS-1:0]  i_hop_data,
   input  logic                  i_hop_sop,
   input  logic                  i_hop_eop,
   input  logic [RCI_NBITS-1:0]  i_rci,
   output logic                  o_hop_ready,
   output logic                  o_hop_fifo_reset0,
   output logic                  o_hop_fifo_reset1,
   output logic                  o_hop_fifo_wr0,
   output logic                  o_hop_fifo_wr1,
   output logic [HOP_NBITS-1:0]  o_hop_fifo_wdata0,
   output logic [HOP_NBITS-1:0]  o_hop_fifo_wdata1,
   output logic                  o_hop_fifo_eop0,
   output logic                  o_hop_fifo_eop1,
   input  logic                  i_hop_fifo_full0,
   input  logic                  i_hop_fifo_full1,
   input  logic                  i_parse_done0,
   input  logic                  i_parse_done1,
   output logic                  o_pp_meta_valid,
   output logic [RCI_NBITS-1:0]  o_pp_meta_rci,
   output logic                  o_trunc_err,
   output logic                  o_proto_err,
   output logic [STAT_NBITS-1:0] o_stat_pkts,
   output logic [STAT_NBITS-1:0] o_stat_drops
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_LOAD, S_DRAIN} state_t;

   state_t                  r_state, w_next;
   logic                    r_wptr;
   logic [1:0]              r_busy;
   logic [HCNT_NBITS-1:0]   r_hop_cnt;
   logic [RCI_NBITS-1:0]    r_rci;

   logic                    w_ready, w_wr, w_drop, w_proto, w_trunc, w_pkt_done;
   logic                    w_start, w_latch_rci, w_full_cur, w_eop_w;

   // ------------------------------------------------------------------ state
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_latch_rci) w_next = S_START;
         S_START: w_next = S_LOAD;
         S_LOAD:  if (w_pkt_done) w_next = i_hop_eop ? S_IDLE : S_DRAIN;
         S_DRAIN: if (i_hop_valid && i_hop_eop) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_ready     = 1'b0;
      w_wr        = 1'b0;
      w_drop      = 1'b0;
      w_proto     = 1'b0;
      w_trunc     = 1'b0;
      w_pkt_done  = 1'b0;
      w_start     = 1'b0;
      w_latch_rci = 1'b0;
      w_full_cur  = r_wptr ? i_hop_fifo_full1 : i_hop_fifo_full0;
      // Truncation forces eop on the last hop that still fits.
      w_eop_w     = i_hop_eop || (r_hop_cnt == HCNT_NBITS'(MAX_HOPS - 1));
      case (r_state)
         S_IDLE: begin
            w_ready     = ~i_hop_sop;
            w_drop      = i_hop_valid & ~i_hop_sop;
            w_proto     = i_hop_valid & ~i_hop_sop;
            w_latch_rci = i_hop_valid & i_hop_sop & ~r_busy[r_wptr];
         end
         S_START: w_start = 1'b1;
         S_LOAD: begin
            w_ready = ~w_full_cur;
            if (i_hop_valid && w_ready) begin
               w_wr       = 1'b1;
               // A sop after the first hop means the previous eop went missing.
               w_proto    = i_hop_sop && (r_hop_cnt != '0);
               w_pkt_done = w_eop_w;
               w_trunc    = w_eop_w & ~i_hop_eop;
            end
         end
         S_DRAIN: begin
            w_ready = 1'b1;
            w_drop  = i_hop_valid;
         end
         default: ;
      endcase
   end

   assign o_hop_ready = w_ready;

   // --------------------------------------------------------------- datapath
   // NOTE: all flops, data registers included, are reset so outputs read 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr            <= 1'b0;
         r_busy            <= 2'b00;
         r_hop_cnt         <= '0;
         r_rci             <= '0;
         o_hop_fifo_reset0 <= 1'b0;
         o_hop_fifo_reset1 <= 1'b0;
         o_hop_fifo_wr0    <= 1'b0;
         o_hop_fifo_wr1    <= 1'b0;
         o_hop_fifo_wdata0 <= '0;
         o_hop_fifo_wdata1 <= '0;
         o_hop_fifo_eop0   <= 1'b0;
         o_hop_fifo_eop1   <= 1'b0;
         o_pp_meta_valid   <= 1'b0;
         o_pp_meta_rci     <= '0;
         o_trunc_err       <= 1'b0;
         o_proto_err       <= 1'b0;
         o_stat_pkts       <= '0;
         o_stat_drops      <= '0;
      end else begin
         if (w_latch_rci) r_rci <= i_rci;
         if (w_pkt_done)  r_wptr <= ~r_wptr;

         if (w_start)      r_hop_cnt <= '0;
         else if (w_wr)    r_hop_cnt <= r_hop_cnt + HCNT_NBITS'(1);

         if (w_start && !r_wptr)  r_busy[0] <= 1'b1;
         else if (i_parse_done0)  r_busy[0] <= 1'b0;
         if (w_start && r_wptr)   r_busy[1] <= 1'b1;
         else if (i_parse_done1)  r_busy[1] <= 1'b0;

         o_hop_fifo_reset0 <= w_start & ~r_wptr;
         o_hop_fifo_reset1 <= w_start &  r_wptr;
         o_pp_meta_valid   <= w_start;
         if (w_start) o_pp_meta_rci <= r_rci;

         o_hop_fifo_wr0  <= w_wr & ~r_wptr;
         o_hop_fifo_wr1  <= w_wr &  r_wptr;
         o_hop_fifo_eop0 <= w_wr & ~r_wptr & w_eop_w;
         o_hop_fifo_eop1 <= w_wr &  r_wptr & w_eop_w;
         if (w_wr && !r_wptr) o_hop_fifo_wdata0 <= i_hop_data;
         if (w_wr &&  r_wptr) o_hop_fifo_wdata1 <= i_hop_data;

         o_trunc_err <= w_trunc;
         o_proto_err <= w_proto;

         // Status counters stick at all-ones instead of wrapping.
         if (w_pkt_done && (o_stat_pkts != '1))
            o_stat_pkts <= o_stat_pkts + STAT_NBITS'(1);
         if (w_drop && (o_stat_drops != '1))
            o_stat_drops <= o_stat_drops + STAT_NBITS'(1);
      end
   end

endmodule

// File: tb/tb_pp_hop_loader.sv
// Directed bench for pp_hop_loader: one task per scenario, inline comparisons
// against hand-computed values, FIFO/meta activity captured by a negedge monitor.
module tb_pp_hop_loader;

   localparam int HOPW = 16;
   localparam int RCIW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_hop_valid = 1'b0;
   logic [HOPW-1:0] i_hop_data = '0;
   logic            i_hop_sop = 1'b0;
   logic            i_hop_eop = 1'b0;
   logic [RCIW-1:0] i_rci = '0;
   logic            o_hop_ready;
   logic            o_reset0, o_reset1, o_wr0, o_wr1, o_eop0, o_eop1;
   logic [HOPW-1:0] o_wdata0, o_wdata1;
   logic            i_full0 = 1'b0, i_full1 = 1'b0;
   logic            i_pd0 = 1'b0, i_pd1 = 1'b0;
   logic            o_meta_valid;
   logic [RCIW-1:0] o_meta_rci;
   logic            o_trunc_err, o_proto_err;
   logic [15:0]     o_stat_pkts, o_stat_drops;

   pp_hop_loader #(.MAX_HOPS(32), .HCNT_NBITS(6), .STAT_NBITS(16),
                   .HOP_NBITS(HOPW), .RCI_NBITS(RCIW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_hop_valid(i_hop_valid), .i_hop_data(i_hop_data),
      .i_hop_sop(i_hop_sop), .i_hop_eop(i_hop_eop), .i_rci(i_rci),
      .o_hop_ready(o_hop_ready),
      .o_hop_fifo_reset0(o_reset0), .o_hop_fifo_reset1(o_reset1),
      .o_hop_fifo_wr0(o_wr0), .o_hop_fifo_wr1(o_wr1),
      .o_hop_fifo_wdata0(o_wdata0), .o_hop_fifo_wdata1(o_wdata1),
      .o_hop_fifo_eop0(o_eop0), .o_hop_fifo_eop1(o_eop1),
      .i_hop_fifo_full0(i_full0), .i_hop_fifo_full1(i_full1),
      .i_parse_done0(i_pd0), .i_parse_done1(i_pd1),
      .o_pp_meta_valid(o_meta_valid), .o_pp_meta_rci(o_meta_rci),
      .o_trunc_err(o_trunc_err), .o_proto_err(o_proto_err),
      .o_stat_pkts(o_stat_pkts), .o_stat_drops(o_stat_drops)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: entries are {eop, data}
   logic [HOPW:0]   q0[$];
   logic [HOPW:0]   q1[$];
   logic [RCIW-1:0] mq[$];
   int n_rst0, n_rst1, n_trunc, n_proto, cyc_rst0, cyc_meta, cyc_wr0_first;

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_wr0) begin
            q0.push_back({o_eop0, o_wdata0});
            if (cyc_wr0_first < 0) cyc_wr0_first = cyc;
         end
         if (o_wr1) q1.push_back({o_eop1, o_wdata1});
         if (o_reset0) begin n_rst0++; cyc_rst0 = cyc; end
         if (o_reset1) n_rst1++;
         if (o_meta_valid) begin mq.push_back(o_meta_rci); cyc_meta = cyc; end
         if (o_trunc_err) n_trunc++;
         if (o_proto_err) n_proto++;
      end
   end

   task automatic clear_mon();
      q0.delete(); q1.delete(); mq.delete();
      n_rst0 = 0; n_rst1 = 0; n_trunc = 0; n_proto = 0;
      cyc_rst0 = -1; cyc_meta = -1; cyc_wr0_first = -1;
   endtask

   task automatic apply_reset();
      i_hop_valid = 0; i_hop_sop = 0; i_hop_eop = 0; i_hop_data = '0; i_rci = '0;
      i_full0 = 0; i_full1 = 0; i_pd0 = 0; i_pd1 = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      clear_mon();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted (bounded wait).
   task automatic drive_beat(input logic [HOPW-1:0] d, input logic sop, input logic eop);
      int n;
      n = 0;
      i_hop_valid = 1; i_hop_data = d; i_hop_sop = sop; i_hop_eop = eop;
      while (1) begin
         @(negedge clk);
         if (o_hop_ready) begin
            @(posedge clk); #1;
            break;
         end
         n++;
         if (n > 200) begin
            n_checks++; n_fail++;
            $display("FAIL beat_accept_timeout: data %0h not accepted within 200 cycles", d);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      i_hop_valid = 0; i_hop_sop = 0; i_hop_eop = 0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      n_checks++;
      if ({o_reset0, o_reset1, o_wr0, o_wr1, o_eop0, o_eop1, o_wdata0, o_wdata1,
           o_meta_valid, o_meta_rci, o_trunc_err, o_proto_err, o_stat_pkts, o_stat_drops} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: some registered output nonzero (pkts %0h drops %0h rci %0h), expected all 0",
                  o_stat_pkts, o_stat_drops, o_meta_rci);
      end
      n_checks++;
      if (o_hop_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 1", o_hop_ready);
      end
      idle(1);
   endtask

   task automatic test_single_packet();
      apply_reset();
      i_rci = 8'd5;
      drive_beat(16'hA1, 1, 0);
      drive_beat(16'hA2, 0, 0);
      drive_beat(16'hA3, 0, 1);
      idle(3);
      n_checks++;
      if (q0.size() != 3 || q1.size() != 0) begin
         n_fail++; $display("FAIL t1_write_count: got wr0=%0d wr1=%0d expected 3/0", q0.size(), q1.size());
      end else begin
         n_checks++;
         if (q0[0] !== {1'b0, 16'hA1} || q0[1] !== {1'b0, 16'hA2} || q0[2] !== {1'b1, 16'hA3}) begin
            n_fail++; $display("FAIL t1_write_data: got %h %h %h expected 0a1 0a2 1a3", q0[0], q0[1], q0[2]);
         end
      end
      n_checks++;
      if (mq.size() != 1 || n_rst0 != 1 || n_rst1 != 0) begin
         n_fail++; $display("FAIL t1_meta_reset: got meta=%0d rst0=%0d rst1=%0d expected 1/1/0", mq.size(), n_rst0, n_rst1);
      end else begin
         n_checks++;
         if (mq[0] !== 8'd5) begin
            n_fail++; $display("FAIL t1_meta_rci: got %0d expected 5", mq[0]);
         end
      end
      n_checks++;
      if (cyc_meta != cyc_rst0 || cyc_wr0_first != cyc_rst0 + 1) begin
         n_fail++; $display("FAIL t1_order: got rst0@%0d meta@%0d wr0@%0d expected meta=rst0, wr0=rst0+1",
                            cyc_rst0, cyc_meta, cyc_wr0_first);
      end
      n_checks++;
      if (o_stat_pkts !== 16'd1) begin
         n_fail++; $display("FAIL t1_stat_pkts: got %0d expected 1", o_stat_pkts);
      end
   endtask

   task automatic test_back_to_back();
      int stalls, t_pd;
      apply_reset();
      i_rci = 8'd1;
      drive_beat(16'h0A0, 1, 0);
      drive_beat(16'h0A1, 0, 1);
      i_rci = 8'd2;
      drive_beat(16'h0B0, 1, 0);
      drive_beat(16'h0B1, 0, 1);
      // Third packet must wait: both buffers are busy
      i_rci = 8'd3;
      i_hop_valid = 1; i_hop_data = 16'h0C0; i_hop_sop = 1; i_hop_eop = 1;
      stalls = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (o_hop_ready === 1'b0 && !o_reset0 && !o_reset1) stalls++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (stalls != 5) begin
         n_fail++; $display("FAIL t2_stall: got %0d stalled cycles expected 5", stalls);
      end
      i_pd0 = 1;
      @(negedge clk);
      t_pd = cyc;
      @(posedge clk); #1;
      i_pd0 = 0;
      drive_beat(16'h0C0, 1, 1);
      idle(3);
      n_checks++;
      if (q0.size() != 3 || q1.size() != 2) begin
         n_fail++; $display("FAIL t2_buffer_split: got wr0=%0d wr1=%0d expected 3/2", q0.size(), q1.size());
      end else begin
         n_checks++;
         if (q0[0] !== {1'b0, 16'h0A0} || q0[1] !== {1'b1, 16'h0A1} ||
             q1[0] !== {1'b0, 16'h0B0} || q1[1] !== {1'b1, 16'h0B1} || q0[2] !== {1'b1, 16'h0C0}) begin
            n_fail++; $display("FAIL t2_data: got %h %h %h / %h %h expected 00a0 10a1 10c0 / 00b0 10b1",
                               q0[0], q0[1], q0[2], q1[0], q1[1]);
         end
      end
      n_checks++;
      if (cyc_rst0 != t_pd + 3 || n_rst0 != 2 || n_rst1 != 1) begin
         n_fail++; $display("FAIL t2_start_timing: got rst0@%0d (pd@%0d) rst0=%0d rst1=%0d expected rst0@pd+3, 2/1",
                            cyc_rst0, t_pd, n_rst0, n_rst1);
      end
      n_checks++;
      if (mq.size() != 3) begin
         n_fail++; $display("FAIL t2_meta_count: got %0d expected 3", mq.size());
      end else begin
         n_checks++;
         if (mq[0] !== 8'd1 || mq[1] !== 8'd2 || mq[2] !== 8'd3) begin
            n_fail++; $display("FAIL t2_meta_rci: got %0d %0d %0d expected 1 2 3", mq[0], mq[1], mq[2]);
         end
      end
   endtask

   task automatic test_backpressure();
      int bad_ready, win_wr;
      apply_reset();
      i_rci = 8'd4;
      drive_beat(16'h0, 1, 0);
      drive_beat(16'h1, 0, 0);
      i_full0 = 1;
      i_hop_valid = 1; i_hop_data = 16'h2; i_hop_sop = 0; i_hop_eop = 0;
      bad_ready = 0; win_wr = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (o_hop_ready !== 1'b0) bad_ready++;
         if (k > 0 && o_wr0) win_wr++;
         @(posedge clk); #1;
      end
      i_full0 = 0;
      n_checks++;
      if (bad_ready != 0 || win_wr != 0) begin
         n_fail++; $display("FAIL t3_full_window: got ready-high=%0d wr0=%0d expected 0/0", bad_ready, win_wr);
      end
      drive_beat(16'h2, 0, 0);
      drive_beat(16'h3, 0, 0);
      drive_beat(16'h4, 0, 1);
      idle(3);
      n_checks++;
      if (q0.size() != 5) begin
         n_fail++; $display("FAIL t3_count: got %0d writes expected 5", q0.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (q0[i] !== {(i == 4), 16'(i)}) begin
               n_fail++; $display("FAIL t3_beat%0d: got %h expected %h", i, q0[i], {(i == 4), 16'(i)});
            end
         end
      end
   endtask

   task automatic test_truncation();
      apply_reset();
      i_rci = 8'd6;
      for (int i = 0; i < 40; i++) drive_beat(16'(i), (i == 0), (i == 39));
      i_rci = 8'd7;
      drive_beat(16'h77, 1, 1);
      idle(3);
      n_checks++;
      if (q0.size() != 32) begin
         n_fail++; $display("FAIL t4_write_count: got %0d expected 32", q0.size());
      end else begin
         n_checks++;
         if (q0[31] !== {1'b1, 16'd31} || q0[30] !== {1'b0, 16'd30} || q0[0] !== {1'b0, 16'd0}) begin
            n_fail++; $display("FAIL t4_eop_pos: got %h %h %h expected 00000 0001e 1001f", q0[0], q0[30], q0[31]);
         end
      end
      n_checks++;
      if (n_trunc != 1 || o_stat_drops !== 16'd8) begin
         n_fail++; $display("FAIL t4_trunc_drops: got trunc=%0d drops=%0d expected 1/8", n_trunc, o_stat_drops);
      end
      n_checks++;
      if (q1.size() != 1 || n_rst1 != 1 || o_stat_pkts !== 16'd2) begin
         n_fail++; $display("FAIL t4_next_buf1: got wr1=%0d rst1=%0d pkts=%0d expected 1/1/2", q1.size(), n_rst1, o_stat_pkts);
      end
   endtask

   task automatic test_protocol_errors();
      apply_reset();
      drive_beat(16'h50, 0, 0);
      idle(3);
      n_checks++;
      if (n_proto != 1 || o_stat_drops !== 16'd1 || q0.size() != 0 || n_rst0 != 0) begin
         n_fail++; $display("FAIL t5_idle_beat: got proto=%0d drops=%0d wr0=%0d rst0=%0d expected 1/1/0/0",
                            n_proto, o_stat_drops, q0.size(), n_rst0);
      end
      i_rci = 8'd8;
      drive_beat(16'h51, 1, 0);
      drive_beat(16'h52, 1, 0);
      drive_beat(16'h53, 0, 1);
      idle(3);
      n_checks++;
      if (n_proto != 2 || n_rst0 != 1 || mq.size() != 1 || o_stat_pkts !== 16'd1 || o_stat_drops !== 16'd1) begin
         n_fail++; $display("FAIL t5_load_sop: got proto=%0d rst0=%0d meta=%0d pkts=%0d drops=%0d expected 2/1/1/1/1",
                            n_proto, n_rst0, mq.size(), o_stat_pkts, o_stat_drops);
      end
      n_checks++;
      if (q0.size() != 3) begin
         n_fail++; $display("FAIL t5_count: got %0d expected 3", q0.size());
      end else begin
         n_checks++;
         if (q0[0] !== {1'b0, 16'h51} || q0[1] !== {1'b0, 16'h52} || q0[2] !== {1'b1, 16'h53}) begin
            n_fail++; $display("FAIL t5_data: got %h %h %h expected 00051 00052 10053", q0[0], q0[1], q0[2]);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      i_rci = 8'h66;
      drive_beat(16'h60, 1, 0);
      drive_beat(16'h61, 0, 0);
      n_checks++;
      if (o_wr0 !== 1'b1 || o_wdata0 !== 16'h61 || o_meta_rci !== 8'h66) begin
         n_fail++; $display("FAIL t6_pre_reset: got wr0=%b data=%h rci=%h expected 1/61/66", o_wr0, o_wdata0, o_meta_rci);
      end
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (o_wr0 !== 1'b0 || o_wdata0 !== '0 || o_meta_rci !== '0) begin
         n_fail++; $display("FAIL t6_async_clear: got wr0=%b data=%h rci=%h expected 0/0/0", o_wr0, o_wdata0, o_meta_rci);
      end
      idle(2);
      rst_n = 1;
      clear_mon();
      i_rci = 8'd9;
      drive_beat(16'h90, 1, 1);
      idle(3);
      n_checks++;
      if (q0.size() != 1 || q1.size() != 0 || n_rst0 != 1 || mq.size() != 1) begin
         n_fail++; $display("FAIL t6_restart: got wr0=%0d wr1=%0d rst0=%0d meta=%0d expected 1/0/1/1",
                            q0.size(), q1.size(), n_rst0, mq.size());
      end else begin
         n_checks++;
         if (q0[0] !== {1'b1, 16'h90} || mq[0] !== 8'd9) begin
            n_fail++; $display("FAIL t6_restart_data: got %h rci=%0d expected 10090/9", q0[0], mq[0]);
         end
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_backpressure();
      test_truncation();
      test_protocol_errors();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
